// File: rtl/seg_display_driver_pkg.sv
// Shared definitions for the seven-segment display driver.
//   - fsm_state_t : capture FSM states (IDLE, CONV)
//   - NUM_DIGITS  : number of multiplexed digits
//   - GLYPH_TABLE : active-low {g,f,e,d,c,b,a} patterns for hex 0..F
//   - SEG_BLANK   : all segments off
package seg_display_driver_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } fsm_state_t;

    localparam int unsigned NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

endpackage

// File: rtl/seg_display_driver_if.sv
// Capture-side bus of the display driver.
//   load    : single-cycle capture strobe
//   sel     : source select (0 = m1_data, 1 = m2_data)
//   m1_data : master 1 read data
//   m2_data : master 2 read data
//   state   : controller state, [3:0] shown on digit3, [4] drives dp
//   busy    : high while a capture is being converted
// master drives the capture request, slave (the driver) returns busy.
interface seg_display_driver_if;
    logic       load;
    logic       sel;
    logic [7:0] m1_data;
    logic [7:0] m2_data;
    logic [4:0] state;
    logic       busy;

    modport master (output load, sel, m1_data, m2_data, state, input busy);
    modport slave  (input load, sel, m1_data, m2_data, state, output busy);
endinterface

// File: rtl/seg_display_driver_bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3).
//   clk, reset : clock, asynchronous active-low reset
//   start      : begin converting bin_in (ignored while running)
//   bin_in     : 8-bit binary value
//   done       : high for one cycle when bcd_out holds the result;
//                asserted in the 8th cycle after the start edge
//   bcd_out    : {hundreds, tens, ones}
module bin2bcd_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  bin_in,
    output logic        done,
    output logic [11:0] bcd_out
);

    logic [19:0] shreg;      // {bcd[11:0], binary[7:0]}
    logic [2:0]  remaining;
    logic        running;

    function automatic logic [19:0] add3_shift(input logic [19:0] v);
        logic [19:0] t;
        t = v;
        for (int unsigned i = 0; i < 3; i++) begin
            if (t[8 + 4*i +: 4] >= 4'd5)
                t[8 + 4*i +: 4] = t[8 + 4*i +: 4] + 4'd3;
        end
        return {t[18:0], 1'b0};
    endfunction

    // The first of the eight shifts needs no add-3 (BCD part is zero), so it
    // is folded into the load; seven more shifts follow, then done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg     <= '0;
            remaining <= '0;
            running   <= 1'b0;
        end else if (start && !running) begin
            shreg     <= {11'b0, bin_in, 1'b0};
            remaining <= 3'd7;
            running   <= 1'b1;
        end else if (running) begin
            if (remaining != 3'd0) begin
                shreg     <= add3_shift(shreg);
                remaining <= remaining - 3'd1;
            end else begin
                running <= 1'b0;
            end
        end
    end

    assign done    = running && (remaining == 3'd0);
    assign bcd_out = shreg[19:8];

endmodule

// File: rtl/seg_display_driver.sv
// Four-digit multiplexed seven-segment display driver.
//   clk     : system clock, rising edge
//   reset   : asynchronous active-low reset
//   bus     : capture bus (seg_display_driver_if.slave)
//   an      : digit anodes, active-low one-hot
//   seg     : segments {g,f,e,d,c,b,a}, active-low
//   dp      : decimal point, active-low (lit on digit3 when state[4]=1)
// Parameter REFRESH_DIV: clock cycles each digit is lit (2..65535).
// Build option SEG_DISP_BCD_EN: decimal display (000-255) via an 8-cycle
// converter; otherwise 2-digit hex with digit2 blank and a 1-cycle CONV.
module seg_display_driver
    import seg_display_driver_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    seg_display_driver_if.slave     bus,
    output logic [3:0]              an,
    output logic [6:0]              seg,
    output logic                    dp
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    fsm_state_t  fsm_q, fsm_d;
    logic [7:0]  cap_val;
    logic [4:0]  cap_state;
    logic [3:0]  digit_q [NUM_DIGITS];
    logic        dp_flag_q;
    logic [CNT_W-1:0] cnt;
    logic [1:0]  idx;
    logic        accept;
    logic        conv_done;
    logic        finish;
    logic [6:0]  seg_next;

    assign accept = (fsm_q == ST_IDLE) && bus.load;
    assign finish = (fsm_q == ST_CONV) && conv_done;

`ifdef SEG_DISP_BCD_EN
    logic [11:0] bcd;

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .reset   (reset),
        .start   (accept),
        .bin_in  ((bus.sel) ? bus.m2_data : bus.m1_data),
        .done    (conv_done),
        .bcd_out (bcd)
    );
`else
    assign conv_done = 1'b1;
`endif

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) fsm_q <= ST_IDLE;
        else        fsm_q <= fsm_d;
    end

    // FSM: next state
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            ST_IDLE: if (bus.load) fsm_d = ST_CONV;
            ST_CONV: if (conv_done) fsm_d = ST_IDLE;
            default: fsm_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.busy = (fsm_q == ST_CONV);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_val   <= '0;
            cap_state <= '0;
        end else if (accept) begin
            cap_val   <= bus.sel ? bus.m2_data : bus.m1_data;
            cap_state <= bus.state;
        end
    end

    // Display registers only change on CONV -> IDLE, all at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) digit_q[i] <= '0;
            dp_flag_q <= 1'b0;
        end else if (finish) begin
`ifdef SEG_DISP_BCD_EN
            digit_q[0] <= bcd[3:0];
            digit_q[1] <= bcd[7:4];
            digit_q[2] <= bcd[11:8];
`else
            digit_q[0] <= cap_val[3:0];
            digit_q[1] <= cap_val[7:4];
            digit_q[2] <= '0;
`endif
            digit_q[3] <= cap_state[3:0];
            dp_flag_q  <= cap_state[4];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        seg_next = GLYPH_TABLE[digit_q[idx]];
`ifndef SEG_DISP_BCD_EN
        if (idx == 2'd2) seg_next = SEG_BLANK;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an  <= 4'b1110;
            seg <= 7'b1000000;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= seg_next;
            dp  <= ~((idx == 2'd3) && dp_flag_q);
        end
    end

endmodule

// File: tb/tb_seg_display_driver.sv
// Self-checking bench for seg_display_driver (REFRESH_DIV = 4).
// Works for both builds; define SEG_DISP_BCD_EN for the decimal build.
module tb_seg_display_driver;

    localparam int unsigned DIV = 4;
`ifdef SEG_DISP_BCD_EN
    localparam int EXP_CONV = 8;
`else
    localparam int EXP_CONV = 1;
`endif

    localparam logic [6:0] REF_GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [6:0] REF_BLANK = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    seg_display_driver_if bus_if ();

    seg_display_driver #(.REFRESH_DIV(DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_val  = 0;   // last completed capture value
    int exp_st   = 0;   // last completed capture state

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int d);
        int nib;
`ifdef SEG_DISP_BCD_EN
        case (d)
            0: nib = exp_val % 10;
            1: nib = (exp_val / 10) % 10;
            2: nib = exp_val / 100;
            default: nib = exp_st % 16;
        endcase
        return REF_GLYPH[nib];
`else
        case (d)
            0: nib = exp_val % 16;
            1: nib = exp_val / 16;
            2: return REF_BLANK;
            default: nib = exp_st % 16;
        endcase
        return REF_GLYPH[nib];
`endif
    endfunction

    // Visit each digit slot once and compare what is shown there.
    task automatic scan_display(input string tag);
        for (int d = 0; d < 4; d++) begin
            logic [3:0] want_an;
            logic       want_dp;
            int         n;
            want_an = 4'b0001 << d;
            want_an = ~want_an;
            want_dp = !(d == 3 && exp_st >= 16);
            n = 0;
            while (an !== want_an && n < int'(4*DIV + 8)) begin
                @(negedge clk);
                n++;
            end
            check_eq({tag, "_slot"}, an, want_an);
            check_eq({tag, "_seg"}, seg, exp_seg(d));
            check_eq({tag, "_dp"}, dp, want_dp);
        end
    endtask

    task automatic do_capture(input logic s, input logic [7:0] d1, input logic [7:0] d2,
                              input logic [4:0] st, input bit inject);
        int cyc;
        @(negedge clk);
        bus_if.sel     = s;
        bus_if.m1_data = d1;
        bus_if.m2_data = d2;
        bus_if.state   = st;
        bus_if.load    = 1'b1;
        @(negedge clk);
        bus_if.load = 1'b0;
        cyc = 0;
        while (bus_if.busy === 1'b1 && cyc < 40) begin
            if (cyc == 0 && inject) begin
                // second request while busy: must be dropped
                bus_if.load    = 1'b1;
                bus_if.sel     = 1'b0;
                bus_if.m1_data = 8'h01;
                bus_if.state   = 5'h00;
            end
            @(negedge clk);
            bus_if.load = 1'b0;
            cyc++;
        end
        check_eq("busy_len", cyc, EXP_CONV);
        exp_val = s ? int'(d2) : int'(d1);
        exp_st  = int'(st);
        @(negedge clk);
        check_eq("busy_idle", bus_if.busy, 1'b0);
        scan_display("disp");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        logic [3:0] cur;
        logic [3:0] want;

        reset          = 1'b0;
        bus_if.load    = 1'b0;
        bus_if.sel     = 1'b0;
        bus_if.m1_data = '0;
        bus_if.m2_data = '0;
        bus_if.state   = '0;

        @(negedge clk);
        @(negedge clk);
        check_eq("rst_an", an, 4'b1110);
        check_eq("rst_seg", seg, 7'b1000000);
        check_eq("rst_dp", dp, 1'b1);
        check_eq("rst_busy", bus_if.busy, 1'b0);

        // Refresh: digit0 slot spans REFRESH_DIV cycles plus the output register.
        reset = 1'b1;
        n = 0;
        while (an === 4'b1110 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("first_slot_len", n, DIV + 1);
        check_eq("rot_1", an, 4'b1101);
        for (int k = 2; k < 6; k++) begin
            cur = an;
            n = 0;
            while (an === cur && n < 40) begin
                @(negedge clk);
                n++;
            end
            check_eq("slot_period", n, DIV);
            want = 4'b0001 << (k % 4);
            want = ~want;
            check_eq("rot_seq", an, want);
        end
        scan_display("rst_disp");

        // FF from m1, state 10111, with an ignored second load during busy.
        do_capture(1'b0, 8'hFF, 8'h00, 5'b10111, 1'b1);
        // 3C from m2.
        do_capture(1'b1, 8'h12, 8'h3C, 5'b00101, 1'b0);

        for (int i = 0; i < 8; i++) begin
            do_capture(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                       5'($urandom), (i % 3) == 1);
        end

        // Reset in the middle of a conversion.
        @(negedge clk);
        bus_if.sel     = 1'b0;
        bus_if.m1_data = 8'hA5;
        bus_if.state   = 5'h1E;
        bus_if.load    = 1'b1;
        @(negedge clk);
        bus_if.load = 1'b0;
        check_eq("busy_pre_rst", bus_if.busy, 1'b1);
        reset = 1'b0;
        #1;
        check_eq("midrst_busy", bus_if.busy, 1'b0);
        check_eq("midrst_an", an, 4'b1110);
        check_eq("midrst_seg", seg, 7'b1000000);
        check_eq("midrst_dp", dp, 1'b1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        exp_val = 0;
        exp_st  = 0;
        @(negedge clk);
        check_eq("postrst_busy", bus_if.busy, 1'b0);
        scan_display("postrst");
        for (int j = 0; j < 12; j++) @(negedge clk);
        check_eq("postrst_busy2", bus_if.busy, 1'b0);
        scan_display("postrst2");

        // Normal operation resumes after the abandoned conversion.
        do_capture(1'b1, 8'h00, 8'hC8, 5'b11010, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_display_driver.md
SEG_DISPLAY_DRIVER -- requirements
Module: seg_display_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, giving the clock cycles each digit is lit (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port load  input  1  single-cycle capture strobe.
REQ-005 SHALL have port sel  input  1  source select: 0 = m1_data, 1 = m2_data.
REQ-006 SHALL have port m1_data  input  8  master 1 read data (m1_data_read).
REQ-007 SHALL have port m2_data  input  8  master 2 read data (m2_data_read).
REQ-008 SHALL have port state  input  5  controller state (controller_state).
REQ-009 SHALL have port busy  output  1  high while a capture is being converted.
REQ-010 SHALL have port an  output  4  digit anodes, active-low, one-hot.
REQ-011 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-012 SHALL have port dp  output  1  decimal point, active-low.

Function
REQ-013 SHALL implement FSM IDLE -> CONV -> IDLE; load in IDLE latches sel-chosen data and state, enters CONV, busy=1 next cycle.
REQ-014 SHALL ignore load while busy=1; no queueing, no effect on the latched value.
REQ-015 SHALL keep display registers at the previous capture during CONV; update all digit registers atomically on the CONV -> IDLE edge, busy=0 the same edge.
REQ-016 SHALL assign digits: digit0 = least significant digit, digit1 = next, digit2 = hundreds (decimal mode) or blank (hex mode), digit3 = hex of latched state[3:0].
REQ-017 SHALL drive dp=0 only while digit3 is lit and latched state[4]=1; otherwise dp=1.
REQ-018 SHALL run a refresh counter 0..REFRESH_DIV-1; on wrap advance digit index 0,1,2,3,0 (wrap-around 3 -> 0).
REQ-019 SHALL register an, seg, dp from the current index: one clock latency from index change to output change.
REQ-020 SHALL use hex glyphs 0-F (A,b,C,d,E,F) and blank = 7'b1111111.
REQ-021 SHALL leave the refresh counter and digit index unaffected by load/CONV.
REQ-022 SHALL, if load and a refresh wrap occur in the same cycle, perform both independently.

Reset
REQ-023 SHALL on reset=0 immediately force: FSM IDLE, busy=0, counter=0, index=0, all latched/display registers 0, an=4'b1110, seg=7'b1000000 ('0'), dp=1.
REQ-024 SHALL abandon a conversion in progress on reset; no partial value ever reaches the display.

Configuration
REQ-025 SHALL compile decimal mode when SEG_DISP_BCD_EN is defined: value shown as 3-digit decimal 000-255, CONV lasts exactly 8 cycles (shift-add-3).
REQ-026 SHALL, without SEG_DISP_BCD_EN, show 2-digit hex 00-FF, digit2 blank, CONV lasts exactly 1 cycle, and omit the converter logic.

Structure
REQ-027 SHALL place in a shared package: the FSM state enum, the 16-entry glyph table, the blank glyph constant, and the digit count (4).
REQ-028 SHALL isolate the sequential binary-to-BCD converter as sub-module bin2bcd_seq (start, 8-bit in, done, 12-bit BCD out), instantiated only under SEG_DISP_BCD_EN.

Verification
REQ-029 SHALL cover: reset release -> an=1110, seg=1000000, dp=1, busy=0; index advances every REFRESH_DIV cycles (use REFRESH_DIV=4).
REQ-030 SHALL cover: BCD build, sel=0, m1_data=8'hFF, load -> busy high 8 cycles, then digits 2,1,0 show 2,5,5.
REQ-031 SHALL cover: hex build, sel=1, m2_data=8'h3C, load -> busy 1 cycle, digits 1,0 show 3,C, digit2 blank.
REQ-032 SHALL cover: state=5'b10111 captured -> digit3 shows 7, dp=0 only during digit3 slot.
REQ-033 SHALL cover: second load during busy with m1_data=8'h01 -> ignored, first value (8'hFF) displayed.
REQ-034 SHALL cover: reset asserted mid-CONV -> busy=0 and display '0' at once; no stale or partial digits afterwards.
